// File: rtl/pbch_pkg.sv
// Shared types and defaults for the PBCH demapper control slice.
package pbch_pkg;

  typedef enum logic [1:0] {RE_OTHER, RE_PBCH, RE_DMRS, RE_RSVD} re_type_t;

  typedef enum logic {IDLE, COLLECT} ctrl_state_t;

  localparam int unsigned PBCH_RE_DEFAULT = 432;

endpackage

// File: rtl/pbch_ctrl_watchdog.sv
// Idle-cycle watchdog: counts cycles without progress while running and
// flags expiry once the count reaches TIMEOUT-1.
module pbch_ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LIM = WW'(TIMEOUT - 1);

  logic [WW-1:0] cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear_i || !run_i) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire_o = run_i && (cnt == LIM);

endmodule

// File: rtl/pbch_demap_ctrl.sv
// PBCH demapper sequencer: opens a block per SSB, forwards PBCH data REs and
// reports done/error. Optional watchdog under `PBCH_CTRL_TIMEOUT_EN.
module pbch_demap_ctrl
  import pbch_pkg::*;
#(
  parameter int unsigned IQ_DW   = 16,
  parameter int unsigned PBCH_RE = PBCH_RE_DEFAULT,
  parameter int unsigned SYM_MAX = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           ssb_start_i,
  input  logic [2*IQ_DW-1:0]             s_axis_in_tdata,
  input  logic [1:0]                     s_axis_in_tuser,
  input  logic                           s_axis_in_tlast,
  input  logic                           s_axis_in_tvalid,
  output logic [2*IQ_DW-1:0]             m_axis_out_tdata,
  output logic [1:0]                     m_axis_out_tuser,
  output logic                           m_axis_out_tlast,
  output logic                           m_axis_out_tvalid,
  output logic                           block_done_o,
  output logic                           block_err_o,
  output logic [$clog2(PBCH_RE+1)-1:0]   re_cnt_o,
  output logic                           busy_o
);

  localparam int unsigned CW = $clog2(PBCH_RE + 1);
  localparam int unsigned SW = $clog2(SYM_MAX + 1);
  localparam logic [CW-1:0] RE_LAST  = CW'(PBCH_RE - 1);
  localparam logic [CW-1:0] RE_FULL  = CW'(PBCH_RE);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_MAX - 1);

  ctrl_state_t   state;
  logic [SW-1:0] sym_cnt;
  logic          start_pend;
  logic          accept;
  logic          sym_end;
  logic          final_re;
  logic          wd_expire;

  always_comb begin
    accept   = s_axis_in_tvalid && (re_type_t'(s_axis_in_tuser) == RE_PBCH);
    sym_end  = s_axis_in_tvalid && s_axis_in_tlast;
    final_re = accept && (re_cnt_o == RE_LAST);
  end

`ifdef PBCH_CTRL_TIMEOUT_EN
  pbch_ctrl_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .run_i    (state == COLLECT),
    .clear_i  (accept || ssb_start_i),
    .expire_o (wd_expire)
  );
`else
  // TIMEOUT stays on the parameter list so both builds share one interface.
  localparam bit WD_PRESENT = 1'b0 && (TIMEOUT > 0);
  assign wd_expire = WD_PRESENT;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      sym_cnt           <= '0;
      start_pend        <= 1'b0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      block_done_o      <= 1'b0;
      block_err_o       <= 1'b0;
      re_cnt_o          <= '0;
      busy_o            <= 1'b0;
    end else begin
      m_axis_out_tuser  <= '0;
      m_axis_out_tlast  <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
      block_done_o      <= 1'b0;
      block_err_o       <= 1'b0;
      case (state)
        IDLE: begin
          start_pend <= 1'b0;
          if ((ssb_start_i || start_pend) && enable_i) begin
            state    <= COLLECT;
            busy_o   <= 1'b1;
            re_cnt_o <= '0;
            sym_cnt  <= '0;
          end
        end
        COLLECT: begin
          if (final_re) begin
            // A start coinciding with the final RE is parked and opened from IDLE next cycle.
            m_axis_out_tdata  <= s_axis_in_tdata;
            m_axis_out_tuser  <= RE_PBCH;
            m_axis_out_tlast  <= 1'b1;
            m_axis_out_tvalid <= 1'b1;
            block_done_o      <= 1'b1;
            re_cnt_o          <= RE_FULL;
            state             <= IDLE;
            busy_o            <= 1'b0;
            start_pend        <= ssb_start_i && enable_i;
          end else if (ssb_start_i) begin
            block_err_o <= 1'b1;
            re_cnt_o    <= '0;
            sym_cnt     <= '0;
            if (!enable_i) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            if (accept) begin
              m_axis_out_tdata  <= s_axis_in_tdata;
              m_axis_out_tuser  <= RE_PBCH;
              m_axis_out_tvalid <= 1'b1;
              re_cnt_o          <= re_cnt_o + 1'b1;
            end
            if (sym_end) begin
              if (sym_cnt == SYM_LAST) begin
                block_err_o <= 1'b1;
                state       <= IDLE;
                busy_o      <= 1'b0;
              end else begin
                sym_cnt <= sym_cnt + 1'b1;
              end
            end else if (wd_expire && !accept) begin
              block_err_o <= 1'b1;
              state       <= IDLE;
              busy_o      <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbch_demap_ctrl.sv
// Self-checking bench for pbch_demap_ctrl: directed block scenarios plus a
// randomized phase, all checked cycle by cycle against a block-level model.
module tb_pbch_demap_ctrl;
  import pbch_pkg::*;

  localparam int unsigned IQ_DW   = 16;
  localparam int unsigned PBCH_RE = 432;
  localparam int unsigned SYM_MAX = 3;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CW      = $clog2(PBCH_RE + 1);
`ifdef PBCH_CTRL_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b0;
  logic                 enable_i = 1'b0;
  logic                 ssb_start_i = 1'b0;
  logic [2*IQ_DW-1:0]   s_axis_in_tdata = '0;
  logic [1:0]           s_axis_in_tuser = '0;
  logic                 s_axis_in_tlast = 1'b0;
  logic                 s_axis_in_tvalid = 1'b0;
  logic [2*IQ_DW-1:0]   m_axis_out_tdata;
  logic [1:0]           m_axis_out_tuser;
  logic                 m_axis_out_tlast;
  logic                 m_axis_out_tvalid;
  logic                 block_done_o;
  logic                 block_err_o;
  logic [CW-1:0]        re_cnt_o;
  logic                 busy_o;

  pbch_demap_ctrl #(
    .IQ_DW   (IQ_DW),
    .PBCH_RE (PBCH_RE),
    .SYM_MAX (SYM_MAX),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .enable_i          (enable_i),
    .ssb_start_i       (ssb_start_i),
    .s_axis_in_tdata   (s_axis_in_tdata),
    .s_axis_in_tuser   (s_axis_in_tuser),
    .s_axis_in_tlast   (s_axis_in_tlast),
    .s_axis_in_tvalid  (s_axis_in_tvalid),
    .m_axis_out_tdata  (m_axis_out_tdata),
    .m_axis_out_tuser  (m_axis_out_tuser),
    .m_axis_out_tlast  (m_axis_out_tlast),
    .m_axis_out_tvalid (m_axis_out_tvalid),
    .block_done_o      (block_done_o),
    .block_err_o       (block_err_o),
    .re_cnt_o          (re_cnt_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Block-level reference: an open block, how many PBCH REs and symbols it has
  // seen, and how long since it last made progress.
  bit          active, pend;
  int          cnt, sym, wd;
  bit          e_valid, e_last, e_done, e_err;
  logic [31:0] e_data;

  // Scenario observation counters, taken from the DUT outputs.
  int n_out, n_done, n_err, n_tlast, last_idx;

  task automatic clear_obs();
    n_out = 0; n_done = 0; n_err = 0; n_tlast = 0; last_idx = 0;
  endtask

  task automatic model_reset();
    active = 0; pend = 0; cnt = 0; sym = 0; wd = 0;
    e_valid = 0; e_last = 0; e_done = 0; e_err = 0; e_data = '0;
  endtask

  task automatic model_step(input bit st, input bit en, input bit v, input logic [1:0] u,
                            input bit l, input logic [31:0] d);
    bit acc;
    acc = v && (u == 2'd1);
    e_valid = 0; e_last = 0; e_done = 0; e_err = 0;
    if (!active) begin
      if ((st || pend) && en) begin
        active = 1; cnt = 0; sym = 0; wd = 0;
      end
      pend = 0;
    end else if (acc && cnt == PBCH_RE - 1) begin
      e_valid = 1; e_last = 1; e_done = 1; e_data = d;
      cnt = PBCH_RE; active = 0; pend = st && en;
    end else if (st) begin
      e_err = 1; cnt = 0; sym = 0; wd = 0; active = en;
    end else begin
      if (acc) begin
        e_valid = 1; e_data = d; cnt++;
      end
      if (v && l) begin
        sym++;
        if (sym == SYM_MAX) begin
          e_err = 1; active = 0;
        end
      end else if (TO_ON && !acc && wd == TIMEOUT - 1) begin
        e_err = 1; active = 0;
      end
      wd = acc ? 0 : wd + 1;
    end
  endtask

  task automatic cycle(input bit st, input bit en, input bit v, input logic [1:0] u, input bit l);
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    ssb_start_i = st; enable_i = en; s_axis_in_tvalid = v;
    s_axis_in_tuser = u; s_axis_in_tlast = l; s_axis_in_tdata = d;
    @(posedge clk);
    model_step(st, en, v, u, l, d);
    #1;
    check("tvalid", m_axis_out_tvalid, e_valid);
    check("tlast", m_axis_out_tlast, e_last);
    check("tuser", m_axis_out_tuser, e_valid ? 2'd1 : 2'd0);
    check("done", block_done_o, e_done);
    check("err", block_err_o, e_err);
    check("re_cnt", re_cnt_o, cnt);
    check("busy", busy_o, active);
    check("done_err_excl", block_done_o & block_err_o, 0);
    if (e_valid) check("tdata", m_axis_out_tdata, e_data);
    if (m_axis_out_tvalid) n_out++;
    if (m_axis_out_tlast) begin n_tlast++; last_idx = n_out; end
    if (block_done_o) n_done++;
    if (block_err_o) n_err++;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(0, en, 0, 2'd0, 0);
  endtask

  // One OFDM symbol: p PBCH and d DMRS REs in random order (a PBCH RE last),
  // with random gaps and non-PBCH filler.
  task automatic symbol(input int p, input int d, input bit tl, input bit st_last, input bit en);
    int  rp, rd;
    bit  dm;
    rp = p; rd = d;
    while (rp + rd > 0) begin
      if ($urandom_range(0, 7) == 0)
        cycle(0, en, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, 0);
      dm = (rd > 0) && ((rp <= 1) || ($urandom_range(0, 2) == 0));
      if (dm) begin
        rd--;
        cycle(0, en, 1, 2'd2, (rp + rd == 0) ? tl : 1'b0);
      end else begin
        rp--;
        if (rp + rd == 0) cycle(st_last, en, 1, 2'd1, tl);
        else              cycle(0, en, 1, 2'd1, 0);
      end
    end
  endtask

  task automatic full_block(input bit st_last);
    symbol(180, 0, 1, 0, 1);
    symbol(72, 48, 1, 0, 1);
    symbol(180, 0, 1, st_last, 1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    ssb_start_i = 0; s_axis_in_tvalid = 0; s_axis_in_tlast = 0;
    #2 reset_i = 1'b1;
    #1;
    check("rst_tvalid", m_axis_out_tvalid, 0);
    check("rst_tdata", m_axis_out_tdata, 0);
    check("rst_done_err", {block_done_o, block_err_o, m_axis_out_tlast}, 0);
    check("rst_re_cnt", re_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_obs();
    apply_reset();

    // Full block of 180/72/180 PBCH REs with DMRS interleaved in symbol 2.
    clear_obs();
    cycle(1, 1, 0, 2'd0, 0);
    full_block(0);
    idle(2, 1);
    check("s1_outs", n_out, PBCH_RE);
    check("s1_done", n_done, 1);
    check("s1_tlast_idx", last_idx, PBCH_RE);
    check("s1_err", n_err, 0);
    check("s1_busy", busy_o, 0);

    // Disabled: nothing opens.
    apply_reset();
    clear_obs();
    cycle(1, 0, 0, 2'd0, 0);
    symbol(180, 0, 1, 0, 0);
    symbol(72, 48, 1, 0, 0);
    symbol(180, 0, 1, 0, 0);
    check("s2_outs", n_out, 0);
    check("s2_re_cnt", re_cnt_o, 0);
    check("s2_done_err", n_done + n_err, 0);

    // Restart after 100 REs, then a complete block.
    clear_obs();
    cycle(1, 1, 0, 2'd0, 0);
    symbol(100, 0, 0, 0, 1);
    cycle(1, 1, 0, 2'd0, 0);
    check("s3_restart_cnt", re_cnt_o, 0);
    check("s3_restart_err", n_err, 1);
    full_block(0);
    idle(1, 1);
    check("s3_done", n_done, 1);
    check("s3_err", n_err, 1);
    check("s3_outs", n_out, 100 + PBCH_RE);

    // Three symbols with only 300 PBCH REs.
    clear_obs();
    cycle(1, 1, 0, 2'd0, 0);
    symbol(100, 0, 1, 0, 1);
    symbol(100, 24, 1, 0, 1);
    symbol(100, 0, 1, 0, 1);
    check("s4_err", n_err, 1);
    check("s4_tlast", n_tlast, 0);
    check("s4_busy", busy_o, 0);
    check("s4_outs", n_out, 300);

    // SSB start on the final RE, then the next block opens by itself.
    clear_obs();
    cycle(1, 1, 0, 2'd0, 0);
    full_block(1);
    check("s5_done", n_done, 1);
    cycle(0, 1, 0, 2'd0, 0);
    check("s5_reopen_busy", busy_o, 1);
    check("s5_reopen_cnt", re_cnt_o, 0);
    full_block(0);
    idle(1, 1);
    check("s5_done2", n_done, 2);
    check("s5_err", n_err, 0);
    check("s5_outs", n_out, 2 * PBCH_RE);

    // Input stall after 10 REs.
    clear_obs();
    cycle(1, 1, 0, 2'd0, 0);
    symbol(10, 0, 0, 0, 1);
    idle(70, 1);
    check("s6_err", n_err, TO_ON ? 1 : 0);
    check("s6_busy", busy_o, TO_ON ? 0 : 1);

    // Asynchronous reset during a block.
    apply_reset();
    cycle(1, 1, 0, 2'd0, 0);
    symbol(50, 0, 0, 0, 1);
    apply_reset();
    idle(2, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 4) != 0,
            ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3)),
            $urandom_range(0, 179) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
